// File: rtl/i2c_pkg.sv
// Shared types and timing helpers for the I2C byte-level master.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START_1  = 3'd1,
    START_2  = 3'd2,
    HOLD     = 3'd3,
    DATA     = 3'd4,
    DATA_ACK = 3'd5,
    STOP_1   = 3'd6,
    STOP_2   = 3'd7
  } state_t;

  localparam int unsigned DEF_CLK_FREQ = 100_000_000;
  localparam int unsigned DEF_I2C_FREQ = 100_000;
  localparam int          BIT_CNT_W    = 3;
  localparam int          PHASE_W      = 2;

  function automatic int unsigned qtr_clocks(input int unsigned clk_freq,
                                             input int unsigned i2c_freq);
    return clk_freq / (i2c_freq * 4);
  endfunction

  function automatic int cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2c_master.sv
// Bit-level I2C master engine: quarter-period timebase, protocol FSM and byte datapath.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
  parameter int unsigned I2C_FREQ = DEF_I2C_FREQ
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       write,
  input  logic       read,
  input  logic [7:0] data_in,
  input  logic       ack_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       scl,
  output logic       done,
  output logic       busy,
  output logic       ack_err,
  output logic [7:0] data_out
);

  localparam int unsigned QTR    = qtr_clocks(CLK_FREQ, I2C_FREQ);
  localparam int          QCNT_W = cnt_width(QTR);
  localparam logic [QCNT_W-1:0] QTR_LAST = QCNT_W'(QTR - 1);

  state_t               state, state_nxt;
  logic [QCNT_W-1:0]    qcnt;
  logic [PHASE_W-1:0]   phase;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [7:0]           shift;
  logic                 cmd_pend, is_rd, ack_lat, from_hold, hold_oe;
  logic                 tick;

  assign tick = (qcnt == QTR_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // sda_oe=1 pulls the line low; 0 releases it to the pull-up.
  always_comb begin
    state_nxt = state;
    scl       = 1'b1;
    sda_oe    = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = START_1;
      START_1: begin
        scl    = (phase == 2'd0) ? !from_hold : 1'b1;
        sda_oe = phase[1];
        if (tick && phase == 2'd3) state_nxt = START_2;
      end
      START_2: begin
        scl    = 1'b0;
        sda_oe = 1'b1;
        if (tick && phase == 2'd1) state_nxt = cmd_pend ? DATA : HOLD;
      end
      HOLD: begin
        scl    = 1'b0;
        sda_oe = hold_oe;
        if (start)              state_nxt = START_1;
        else if (stop)          state_nxt = STOP_1;
        else if (write || read) state_nxt = DATA;
      end
      DATA: begin
        scl    = (phase == 2'd1) || (phase == 2'd2);
        sda_oe = !is_rd && !shift[bit_cnt];
        if (tick && phase == 2'd3 && bit_cnt == '0) state_nxt = DATA_ACK;
      end
      DATA_ACK: begin
        scl    = (phase == 2'd1) || (phase == 2'd2);
        sda_oe = is_rd && !ack_lat;
        if (tick && phase == 2'd3) state_nxt = HOLD;
      end
      STOP_1: begin
        scl    = phase[0];
        sda_oe = 1'b1;
        if (tick && phase == 2'd1) state_nxt = STOP_2;
      end
      STOP_2: if (tick && phase == 2'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      qcnt      <= '0;
      phase     <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      cmd_pend  <= 1'b0;
      is_rd     <= 1'b0;
      ack_lat   <= 1'b0;
      from_hold <= 1'b0;
      hold_oe   <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      ack_err   <= 1'b0;
      data_out  <= '0;
    end else begin
      done <= 1'b0;
      // Timebase is parked in the waiting states and restarts on every state change.
      if (state == IDLE || state == HOLD || state_nxt != state) begin
        qcnt  <= '0;
        phase <= '0;
      end else if (tick) begin
        qcnt  <= '0;
        phase <= phase + 2'd1;
      end else begin
        qcnt <= qcnt + 1'b1;
      end

      case (state)
        IDLE: if (start) begin
          busy      <= 1'b1;
          ack_err   <= 1'b0;
          from_hold <= 1'b0;
          cmd_pend  <= write || read;
          is_rd     <= !write;
          shift     <= data_in;
          ack_lat   <= ack_in;
        end
        HOLD: begin
          if (start) begin
            from_hold <= 1'b1;
            cmd_pend  <= write || read;
            is_rd     <= !write;
            shift     <= data_in;
            ack_lat   <= ack_in;
          end else if (!stop && write) begin
            is_rd   <= 1'b0;
            shift   <= data_in;
            bit_cnt <= 3'd7;
          end else if (!stop && read) begin
            is_rd   <= 1'b1;
            ack_lat <= ack_in;
            bit_cnt <= 3'd7;
          end
        end
        START_2: if (tick && phase == 2'd1) begin
          cmd_pend <= 1'b0;
          if (cmd_pend) begin
            bit_cnt <= 3'd7;
          end else begin
            done    <= 1'b1;
            hold_oe <= 1'b1;
          end
        end
        DATA: begin
          if (tick && phase == 2'd1 && is_rd) shift[bit_cnt] <= sda_in;
          if (tick && phase == 2'd3 && bit_cnt != '0) bit_cnt <= bit_cnt - 3'd1;
        end
        DATA_ACK: begin
          if (tick && phase == 2'd1 && !is_rd) ack_err <= sda_in;
          if (tick && phase == 2'd3) begin
            done    <= 1'b1;
            hold_oe <= is_rd && !ack_lat;
            if (is_rd) data_out <= shift;
          end
        end
        STOP_2: if (tick && phase == 2'd1) begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/top_i2c_master.sv
// I2C master top: open-drain SDA pad around the bit-level engine.
module top_i2c_master
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
  parameter int unsigned I2C_FREQ = DEF_I2C_FREQ
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       write,
  input  logic       read,
  input  logic [7:0] data_in,
  input  logic       ack_in,
  inout  wire        sda,
  output logic       scl,
  output logic       done,
  output logic       busy,
  output logic       ack_err,
  output logic [7:0] data_out
);

  logic sda_oe;

  assign sda = sda_oe ? 1'b0 : 1'bz;

  i2c_master #(
    .CLK_FREQ(CLK_FREQ),
    .I2C_FREQ(I2C_FREQ)
  ) U_i2c_master (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .write    (write),
    .read     (read),
    .data_in  (data_in),
    .ack_in   (ack_in),
    .sda_in   (sda),
    .sda_oe   (sda_oe),
    .scl      (scl),
    .done     (done),
    .busy     (busy),
    .ack_err  (ack_err),
    .data_out (data_out)
  );

endmodule

// File: tb/tb_top_i2c_master.sv
// Bench for top_i2c_master: bus-level slave model, scoreboard queues for bus events and done pulses.
module tb_top_i2c_master;

  localparam int QTR = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, stop = 1'b0, write = 1'b0, read = 1'b0, ack_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  wire        sda;
  logic       scl, done, busy, ack_err;
  logic [7:0] data_out;
  logic       slave_oe = 1'b0;
  logic [2:0] st;

  pullup (sda);
  assign sda = slave_oe ? 1'b0 : 1'bz;
  assign st  = dut.U_i2c_master.state;

  always #5 clk = ~clk;

  top_i2c_master #(.CLK_FREQ(4_000_000), .I2C_FREQ(100_000)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .write(write), .read(read),
    .data_in(data_in), .ack_in(ack_in), .sda(sda), .scl(scl), .done(done),
    .busy(busy), .ack_err(ack_err), .data_out(data_out)
  );

  // Bus events: {kind(0 byte,1 start,2 stop), fsm state, byte, ninth bit}
  logic [13:0] exp_bus_q[$];
  // Done pulses: {busy, ack_err, data_out, fsm state}
  logic [12:0] exp_done_q[$];

  int         n_tests = 0, n_fail = 0;
  logic       m_busy = 1'b0, m_ack_err = 1'b0;
  logic [7:0] m_rx = 8'h00;

  logic       slave_req = 1'b0, slave_tx = 1'b0, slave_nack = 1'b0;
  logic [7:0] slave_byte = 8'h00;
  int         start_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  task automatic bus_event(input logic [13:0] ev);
    if (exp_bus_q.size() == 0) fail_now("bus_unexpected");
    else check("bus_event", 32'(ev), 32'(exp_bus_q.pop_front()));
  endtask

  // Bus monitor and I2C slave: decode START/STOP/bits, drive slave bits while SCL is low.
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  int         bit_n = 0;
  logic [8:0] bits = 9'h0;
  always @(negedge clk) begin
    if (reset) begin
      bit_n     = 0;
      slave_oe  = 1'b0;
      slave_req = 1'b0;
    end else begin
      if (scl && prev_scl && prev_sda && !sda) begin
        bus_event({2'd1, st, 9'h000});
        bit_n = 0;
        start_seen++;
      end else if (scl && prev_scl && !prev_sda && sda) begin
        bus_event({2'd2, st, 9'h000});
        bit_n = 0;
      end
      if (!prev_scl && scl) begin
        bits = {bits[7:0], sda};
        bit_n++;
        if (bit_n == 9) begin
          bus_event({2'd0, st, bits});
          bit_n     = 0;
          slave_req = 1'b0;
        end
      end
      if (!scl)
        slave_oe = slave_req && (slave_tx ? (bit_n < 8 && !slave_byte[7 - bit_n])
                                          : (bit_n == 8 && !slave_nack));
    end
    prev_scl = scl;
    prev_sda = sda;
  end

  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_done_q.size() == 0) fail_now("done_unexpected");
      else check("done", 32'({busy, ack_err, data_out, st}), 32'(exp_done_q.pop_front()));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_cmd(input logic s, input logic p, input logic w, input logic r,
                           input logic [7:0] d, input logic a);
    start = s; stop = p; write = w; read = r; data_in = d; ack_in = a;
    cycle();
    start = 1'b0; stop = 1'b0; write = 1'b0; read = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    @(negedge clk);
    while (!done && n < 100 * QTR) begin
      @(negedge clk);
      n++;
    end
    if (!done) fail_now({name, "_timeout"});
    cycle();
  endtask

  task automatic wait_start(input int s0);
    int n = 0;
    while (start_seen == s0 && n < 50 * QTR) begin
      @(negedge clk);
      n++;
    end
    if (start_seen == s0) fail_now("start_timeout");
    #1;
  endtask

  // kind: 0 bare START, 1 START+write, 2 START+read
  task automatic op_start(input int kind, input logic [7:0] d, input logic a, input logic nack);
    int s0;
    if (!m_busy) m_ack_err = 1'b0;
    m_busy = 1'b1;
    exp_bus_q.push_back({2'd1, 3'd1, 9'h000});
    if (kind == 1) begin
      exp_bus_q.push_back({2'd0, 3'd5, d, nack});
      m_ack_err = nack;
    end else if (kind == 2) begin
      exp_bus_q.push_back({2'd0, 3'd5, d, a});
      m_rx = d;
    end
    exp_done_q.push_back({1'b1, m_ack_err, m_rx, 3'd3});
    s0 = start_seen;
    pulse_cmd(1'b1, 1'b0, kind == 1, kind == 2, d, a);
    wait_start(s0);
    slave_tx = (kind == 2); slave_byte = d; slave_nack = nack; slave_req = (kind != 0);
    wait_done("start");
  endtask

  task automatic op_write(input logic [7:0] d, input logic nack);
    exp_bus_q.push_back({2'd0, 3'd5, d, nack});
    m_ack_err = nack;
    exp_done_q.push_back({1'b1, m_ack_err, m_rx, 3'd3});
    slave_tx = 1'b0; slave_nack = nack; slave_req = 1'b1;
    pulse_cmd(1'b0, 1'b0, 1'b1, 1'b0, d, 1'b0);
    wait_done("write");
  endtask

  task automatic op_read(input logic [7:0] d, input logic a);
    exp_bus_q.push_back({2'd0, 3'd5, d, a});
    m_rx = d;
    exp_done_q.push_back({1'b1, m_ack_err, m_rx, 3'd3});
    slave_tx = 1'b1; slave_byte = d; slave_req = 1'b1;
    pulse_cmd(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, a);
    wait_done("read");
  endtask

  task automatic op_stop();
    exp_bus_q.push_back({2'd2, 3'd7, 9'h000});
    m_busy = 1'b0;
    exp_done_q.push_back({1'b0, m_ack_err, m_rx, 3'd0});
    pulse_cmd(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    wait_done("stop");
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_scl"},      32'(scl), 32'd1);
    check({tag, "_sda"},      32'(sda), 32'd1);
    check({tag, "_busy"},     32'(busy), 32'd0);
    check({tag, "_done"},     32'(done), 32'd0);
    check({tag, "_ack_err"},  32'(ack_err), 32'd0);
    check({tag, "_data_out"}, 32'(data_out), 32'd0);
    check({tag, "_state"},    32'(st), 32'd0);
  endtask

  initial begin
    #900us;
    fail_now("watchdog");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int s0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    cycle();
    reset = 1'b0;
    repeat (3) cycle();

    // Commands other than start are ignored while idle.
    pulse_cmd(1'b0, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0);
    repeat (3 * QTR) cycle();
    check("idle_ignore_state", 32'(st), 32'd0);
    check("idle_ignore_busy",  32'(busy), 32'd0);
    check("idle_ignore_scl",   32'(scl), 32'd1);

    op_start(1, 8'hA0, 1'b0, 1'b0);
    op_write(8'hA0, 1'b1);
    op_start(2, 8'h11, 1'b0, 1'b0);
    op_read(8'h22, 1'b0);
    op_read(8'h33, 1'b1);
    op_stop();

    for (int k = 0; k < 6; k++) begin
      op_start(int'($urandom_range(0, 2)), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int j = 0; j < int'($urandom_range(1, 4)); j++) begin
        case ($urandom_range(0, 3))
          0: op_write(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
          1, 2: op_read(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
          default: op_start(int'($urandom_range(0, 2)), 8'($urandom_range(0, 255)),
                            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        endcase
      end
      op_stop();
    end

    // Reset in the middle of a written byte.
    m_busy = 1'b1;
    exp_bus_q.push_back({2'd1, 3'd1, 9'h000});
    s0 = start_seen;
    pulse_cmd(1'b1, 1'b0, 1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0);
    wait_start(s0);
    slave_tx = 1'b0; slave_nack = 1'b0; slave_req = 1'b1;
    repeat (10 * QTR) cycle();
    exp_bus_q.delete();
    exp_done_q.delete();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle("mid_reset");
    cycle();
    reset = 1'b0;
    m_busy = 1'b0; m_ack_err = 1'b0; m_rx = 8'h00; slave_req = 1'b0;
    repeat (3) cycle();

    op_start(1, 8'h3C, 1'b0, 1'b0);
    op_read(8'hC5, 1'b1);
    op_stop();

    repeat (20) cycle();
    check("bus_q_empty",  32'(exp_bus_q.size()), 32'd0);
    check("done_q_empty", 32'(exp_done_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/top_i2c_master.md
Name: top_i2c_master

Overview:
- Single-master I2C byte-level controller; wraps one bit-level engine and exposes a command-pulse interface (start/write/read/stop) to a host FSM.
- Generates SCL, drives SDA open-drain, and reports per-byte completion, busy status, slave-NACK and received data.
- Supports repeated START and multi-byte reads, with host-selected ACK/NACK per byte.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- I2C_FREQ, 100_000, SCL frequency in Hz.
- QTR, CLK_FREQ/(I2C_FREQ*4) = 250, system clocks per quarter SCL period.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  level; request START (or repeated START from HOLD).
- stop  in  1  level; request STOP from HOLD.
- write  in  1  level; transmit data_in.
- read  in  1  level; receive one byte.
- data_in  in  8  byte to transmit, MSB first.
- ack_in  in  1  master ACK bit after a read byte: 0 = ACK (continue), 1 = NACK (last byte).
- sda  inout  1  open-drain; driven 0 or released to Z; external pull-up.
- scl  out  1  push-pull serial clock.
- done  out  1  one-cycle pulse when a byte+ACK completes, a bare START completes, or a STOP completes.
- busy  out  1  high from the accepted START until STOP completes.
- ack_err  out  1  high if the slave NACKed the most recent written byte.
- data_out  out  8  last received byte.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset); both fixed.
- Reset values, also on reset mid-transfer: state IDLE, scl=1, sda released, done=0, busy=0, ack_err=0, data_out=0x00, shift/counters cleared.
- State encoding is fixed: IDLE=0, START_1=1, START_2=2, HOLD=3, DATA=4, DATA_ACK=5, STOP_1=6, STOP_2=7.
- Every phase is a quarter period of QTR clocks.
- IDLE: scl=1, sda released, busy=0.
  - start=1 -> START_1 and busy=1.
  - Latch pending command on the same edge: write has priority over read; latch data_in.
  - stop, write and read alone are ignored in IDLE.
- START_1, four quarters:
  - Q0: sda released; scl=1 from IDLE, scl=0 when entered from HOLD.
  - Q1: sda released, scl=1.
  - Q2 and Q3: sda=0, scl=1.
- START_2: sda=0, scl=0 for 2 quarters.
  - If a command is pending -> DATA.
  - Otherwise -> HOLD with done pulse.
- HOLD: scl=0; sda held at the last ack-phase level, released when reading.
  - Priority, sampled each clock: start > stop > write > read.
  - start -> START_1 (repeated START), latching write/read/data_in as a pending command.
  - write -> DATA (tx, shift=data_in).
  - read -> DATA (rx).
  - stop -> STOP_1.
- DATA: 8 bits, MSB first. Per bit:
  - Q0: scl=0, master updates sda (tx) or releases it (rx).
  - Q1: scl=1.
  - Q2: scl=1; sample sda at Q2 start.
  - Q3: scl=0.
  - After bit 0 -> DATA_ACK.
- DATA_ACK: same 4-quarter timing.
  - tx: sda released; sampled level goes to ack_err (1 = NACK).
  - rx: sda driven to ack_in; data_out updated with the received byte.
  - End of phase -> HOLD with done pulse.
  - A NACK does not abort; the host decides.
- STOP_1: sda=0; scl=0 for 1 quarter, then scl=1 for 1 quarter.
- STOP_2: scl=1, sda released for 2 quarters, then IDLE with done pulse and busy=0 in the same cycle.
- ack_err is cleared when a START is accepted from IDLE.
- Commands held high longer than needed are harmless: they are sampled only in IDLE/HOLD.

Decomposition:
- Shared package i2c_pkg holds:
  - state enum with the fixed encoding;
  - QTR-derived constants;
  - bit-count width.
- One sub-module i2c_master, instance name U_i2c_master, contains the FSM and exposes a register named state.
- top_i2c_master contains only the open-drain tristate (sda = sda_oe ? 0 : Z) and pass-through wiring.

Test Plan:
- Reset/idle: reset 100 ns -> scl=1, sda=Z (pulled 1), busy=0, done=0, data_out=0x00.
- START+write 0xA0, slave ACK:
  - SDA falls while SCL high.
  - Bits 1,0,1,0,0,0,0,0 appear on 8 SCL pulses.
  - done pulses after the 9th pulse; ack_err=0; busy=1.
- Same write with slave NACK -> ack_err=1 at done; FSM in HOLD.
- Repeated START: from HOLD, start+read -> state passes through 1.
  - SDA goes low while SCL high.
  - Slave sends 0x11 -> data_out=0x11; master drives ACK (0) on the 9th bit.
- Multi-byte read: read pulses with slave 0x22, then 0x33 with ack_in=1.
  - data_out=0x22 then 0x33.
  - 9th bit of the last byte is released/high (NACK).
- STOP: stop in HOLD -> SDA rises while SCL high, done pulse, busy=0, state=IDLE.
- Reset asserted mid-byte -> next cycle scl=1, sda released, busy=0.
